instr_encoder: RTL and testbench



---
 rtl/rv32i_types.sv | 40 ++++
 rtl/instr_encoder_fifo.sv | 67 ++++++
 rtl/instr_encoder.sv | 121 ++++++++++++
 tb/tb_instr_encoder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I opcode/format types and the queued encode result.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui    = 7'b0110111,
        op_auipc  = 7'b0010111,
        op_jal    = 7'b1101111,
        op_jalr   = 7'b1100111,
        op_br     = 7'b1100011,
        op_load   = 7'b0000011,
        op_store  = 7'b0100011,
        op_imm    = 7'b0010011,
        op_reg    = 7'b0110011,
        op_csr    = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j, fmt_bad
    } rv32i_format;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } enc_entry_t;

    function automatic rv32i_format format_of(input logic [6:0] op);
        rv32i_format f;
        case (op)
            op_lui, op_auipc:                   f = fmt_u;
            op_jal:                             f = fmt_j;
            op_jalr, op_load, op_imm, op_csr:   f = fmt_i;
            op_br:                              f = fmt_b;
            op_store:                           f = fmt_s;
            op_reg:                             f = fmt_r;
            default:                            f = fmt_bad;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Two-entry ring buffer of encode results; head is presented from registers.
module instr_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  enc_entry_t in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output enc_entry_t out_data
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    enc_entry_t mem_q [2];
    enc_entry_t mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    // Ready drops while reset is held so nothing is accepted into a flushing queue.
    assign in_ready  = (count_q < FULL) && !rst;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mem
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Builds RV32I instruction words from fields, flags unencodable immediates,
// queues results and keeps saturating encode/error counters.
module instr_encoder
    import rv32i_types::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  rv32i_opcode      opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    logic [6:0]       op_bits;
    rv32i_format      fmt;
    logic             fit_12, fit_13, fit_21;
    enc_entry_t       enc, head;
    logic             accept;
    logic [CNT_W-1:0] enc_count_q, enc_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    assign op_bits = opcode;
    assign fmt     = format_of(op_bits);
    // Sign-extension checks: upper bits must all match the sign bit of the field.
    assign fit_12  = (&imm[31:11]) || !(|imm[31:11]);
    assign fit_13  = (&imm[31:12]) || !(|imm[31:12]);
    assign fit_21  = (&imm[31:20]) || !(|imm[31:20]);

    always_comb begin
        enc.word = 32'h0;
        enc.err  = 1'b0;
        case (fmt)
            fmt_r: enc.word = {funct7, rs2, rs1, funct3, rd, op_bits};
            fmt_i: begin
                if (op_bits == op_imm && funct3[1:0] == 2'b01) begin
                    enc.word = {funct7, imm[4:0], rs1, funct3, rd, op_bits};
                    enc.err  = |imm[31:5];
                end else begin
                    enc.word = {imm[11:0], rs1, funct3, rd, op_bits};
                    enc.err  = !fit_12;
                end
            end
            fmt_s: begin
                enc.word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op_bits};
                enc.err  = !fit_12;
            end
            fmt_b: begin
                enc.word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op_bits};
                enc.err  = imm[0] || !fit_13;
            end
            fmt_u: begin
                enc.word = {imm[31:12], rd, op_bits};
                enc.err  = |imm[11:0];
            end
            fmt_j: begin
                enc.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op_bits};
                enc.err  = imm[0] || !fit_21;
            end
            default: begin
                enc.word = 32'h0;
                enc.err  = 1'b1;
            end
        endcase
    end

    instr_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (enc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_word = head.word;
    assign out_err  = head.err;
    assign accept   = in_valid && in_ready;

    always_comb begin
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (accept && !(&enc_count_q)) begin
            enc_count_d = enc_count_q + 1'b1;
        end
        if (accept && enc.err && !(&err_count_q)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver pushes expected words, monitor pops on output handshakes.
module tb_instr_encoder;
    import rv32i_types::*;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    rv32i_opcode      opcode;
    logic [4:0]       rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]       funct3 = '0;
    logic [6:0]       funct7 = '0;
    logic [31:0]      imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_word;
    logic             out_err;
    logic [CNT_W-1:0] enc_count, err_count;

    instr_encoder #(.DEPTH(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];
    logic [31:0] drv_word;
    logic        drv_err;
    int          acc_cnt = 0;
    int          acc_err = 0;
    int          last_stalls = 0;
    bit          hold_valid = 0;
    logic [32:0] hold_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Reference: field placement by plain shifts, range by signed integer bounds.
    function automatic void model(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                  input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] im, output logic [31:0] w, output logic e);
        longint s;
        logic [31:0] regs;
        s = longint'($signed(im));
        regs = (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12);
        w = 32'h0;
        e = 1'b0;
        case (op)
            7'h37, 7'h17: begin
                w = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
                e = (im % 4096) != 0;
            end
            7'h67, 7'h03, 7'h13, 7'h73: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    w = (32'(f7) << 25) | ((im & 31) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
                    e = im > 31;
                end else begin
                    w = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
                    e = (s < -2048) || (s > 2047);
                end
            end
            7'h23: begin
                w = (((im >> 5) & 127) << 25) | regs | ((im & 31) << 7) | 32'(op);
                e = (s < -2048) || (s > 2047);
            end
            7'h63: begin
                w = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | regs |
                    (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7) | 32'(op);
                e = (s % 2 != 0) || (s < -4096) || (s > 4095);
            end
            7'h6F: begin
                w = (((im >> 20) & 1) << 31) | (((im >> 1) & 1023) << 21) | (((im >> 11) & 1) << 20) |
                    (((im >> 12) & 255) << 12) | (32'(d) << 7) | 32'(op);
                e = (s % 2 != 0) || (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 1);
            end
            7'h33: w = (32'(f7) << 25) | regs | (32'(d) << 7) | 32'(op);
            default: begin
                w = 32'h0;
                e = 1'b1;
            end
        endcase
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 0;
        end else begin
            if (hold_valid && out_valid) begin
                check("head_stable", {31'b0, ({out_word, out_err} === hold_val)}, 32'd1);
            end
            hold_valid = out_valid && !out_ready;
            hold_val   = {out_word, out_err};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got 0x%08h expected no output", out_word);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("out_word", out_word, e[32:1]);
                    check("out_err", {31'b0, out_err}, {31'b0, e[0]});
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({drv_word, drv_err});
                acc_cnt++;
                if (drv_err) acc_err++;
            end
        end
    end

    task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] im, input bit use_c, input logic [31:0] cw, input bit ce);
        logic [31:0] w;
        logic        e;
        int          stalls;
        model(op, d, s1, s2, f3, f7, im, w, e);
        if (use_c) begin
            w = cw;
            e = ce;
        end
        opcode = rv32i_opcode'(op);
        rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
        drv_word = w;
        drv_err  = e;
        in_valid = 1'b1;
        stalls = 0;
        @(negedge clk);
        while (!in_ready && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 50) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last_stalls = stalls;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h7F};
    int         edge_imm [10] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4097, 1048574, -1048576};

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: return 32'($signed($urandom_range(0, 4095)) - 2048);
            2: return 32'(edge_imm[$urandom_range(0, 9)]);
            3: return $urandom & 32'hFFFFF000;
            4: return 32'($urandom_range(0, 63));
            default: return 32'($signed($urandom_range(0, 2097151)) - 1048576);
        endcase
    endfunction

    bit rand_done = 0;
    int total_stalls;

    initial begin
        opcode = op_imm;
        #2;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_word", out_word, 32'h0);
        check("rst_out_err", {31'b0, out_err}, 32'd0);
        check("rst_enc_count", 32'(enc_count), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed vectors with known encodings
        out_ready = 1'b1;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500093, 0);
        check("latency_out_valid", {31'b0, out_valid}, 32'd1);
        drain();
        check("enc_count_1", 32'(enc_count), 32'd1);
        send(7'h23, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1, 32'h0020A423, 0);
        send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 1, 32'hFE000EE3, 0);
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1, 32'h123452B7, 0);
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 32'h001000EF, 0);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1, 32'h80000093, 1);
        drain();
        check("err_count_1", 32'(err_count), 32'd1);
        send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 0, 32'h0, 0);
        send(7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1, 0, 32'h0, 0);
        send(7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 7'd1, 32'h0, 1, 32'h0, 1);
        send(7'h13, 5'd2, 5'd3, 5'd0, 3'b101, 7'h20, 32'd7, 0, 32'h0, 0);
        send(7'h13, 5'd2, 5'd3, 5'd0, 3'b001, 7'h00, 32'd32, 0, 32'h0, 0);
        drain();
        check("err_count_dir", 32'(err_count), 32'(acc_err));

        // Backpressure: three back-to-back with consumer stalled
        out_ready = 1'b0;
        send(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'h0, 0, 32'h0, 0);
        send(7'h33, 5'd4, 5'd5, 5'd6, 3'd7, 7'h00, 32'h0, 0, 32'h0, 0);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        fork
            send(7'h67, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd100, 0, 32'h0, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("enc_count_bp", 32'(enc_count), 32'(acc_cnt));

        // Streaming throughput
        total_stalls = 0;
        for (int i = 0; i < 100; i++) begin
            send(7'h13, 5'(i), 5'(i + 1), 5'd0, 3'd0, 7'd0, 32'(i), 0, 32'h0, 0);
            total_stalls += last_stalls;
        end
        check("stream_stalls", 32'(total_stalls), 32'd0);
        drain();
        check("enc_count_stream", 32'(enc_count), 32'(acc_cnt));

        // Randomized fields with random consumer backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(ops[$urandom_range(0, 10)], 5'($urandom), 5'($urandom), 5'($urandom),
                         3'($urandom), 7'($urandom), rand_imm(), 0, 32'h0, 0);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("enc_count_rand", 32'(enc_count), 32'(acc_cnt));
        check("err_count_rand", 32'(err_count), 32'(acc_err));

        // Reset with two entries queued
        out_ready = 1'b0;
        send(7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'd0, 32'h0, 0, 32'h0, 0);
        send(7'h33, 5'd10, 5'd11, 5'd12, 3'd0, 7'd0, 32'h0, 0, 32'h0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        check("midrst_enc_count", 32'(enc_count), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        exp_q.delete();
        acc_cnt = 0;
        acc_err = 0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("postrst_out_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1, 32'h123452B7, 0);
        drain();
        check("postrst_enc_count", 32'(enc_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
